// File: rtl/kmeans_iter_ctrl.sv
// rtl/kmeans_iter_ctrl.sv - K-means iteration controller (4 clusters, Q8.8)
// Holds the point set and four centroids, streams points to an external
// nearest-centroid unit, accumulates per-cluster sums/counts from returned
// labels, recomputes centroids on a shared serial divider and repeats until
// no label changes or ITER_MAX iterations have run.
// Ports: ld_* / cinit_* load points and centroids while idle; start begins a
// run; data_* and cent_*_bus feed the assignment unit, cluster_result and
// output_valid return its labels; busy, done, converged, iter_count report.
module kmeans_iter_ctrl #(
    parameter int N_POINTS = 16,
    parameter int ITER_MAX = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        ld_valid,
    input  logic [$clog2(N_POINTS)-1:0] ld_addr,
    input  logic [15:0]                 ld_x,
    input  logic [15:0]                 ld_y,
    input  logic                        cinit_valid,
    input  logic [1:0]                  cinit_idx,
    input  logic [15:0]                 cinit_x,
    input  logic [15:0]                 cinit_y,
    input  logic                        start,
    output logic [15:0]                 data_x,
    output logic [15:0]                 data_y,
    output logic                        data_valid,
    output logic [63:0]                 cent_x_bus,
    output logic [63:0]                 cent_y_bus,
    input  logic [1:0]                  cluster_result,
    input  logic                        output_valid,
    output logic                        busy,
    output logic                        done,
    output logic                        converged,
    output logic [3:0]                  iter_count
);
    localparam int AW = $clog2(N_POINTS);
    localparam int SW = 16 + AW;
    localparam int CW = AW + 1;
    localparam logic [AW:0] LAST_IDX = (AW+1)'(N_POINTS - 1);
    localparam logic [AW:0] N_IDX    = (AW+1)'(N_POINTS);
    localparam logic [3:0]  ITER_LIM = 4'(ITER_MAX);

    typedef enum logic [2:0] {S_IDLE, S_ASSIGN, S_DRAIN, S_UPDATE, S_CHECK} state_t;
    state_t state, state_next;

    logic [15:0]   pt_x [N_POINTS];
    logic [15:0]   pt_y [N_POINTS];
    logic [15:0]   cent_x [4];
    logic [15:0]   cent_y [4];
    logic [1:0]    label [N_POINTS];
    logic [SW-1:0] sum_x [4];
    logic [SW-1:0] sum_y [4];
    logic [CW-1:0] cnt [4];
    logic          changed;
    logic [AW:0]   issue_idx, result_idx;
    logic [1:0]    div_k;
    logic [4:0]    div_step;
    logic [CW-1:0] rem_x, rem_y, divisor;
    logic [15:0]   quo_x, quo_y;
    logic [3:0]    iter_q;
    logic          done_q, converged_q;

    logic          collect, all_back, div_last;
    logic [AW-1:0] r_addr;
    logic [CW-1:0] trial_x, trial_y, rem_x_nxt, rem_y_nxt;
    logic [15:0]   quo_x_nxt, quo_y_nxt;

    assign collect  = output_valid && (state == S_ASSIGN || state == S_DRAIN) && (result_idx < N_IDX);
    assign r_addr   = result_idx[AW-1:0];
    // UPDATE must start the cycle after the final label, so look at this cycle's label too.
    assign all_back = (result_idx == N_IDX) || (collect && result_idx == LAST_IDX);
    assign div_last = (div_step == 5'd16);

    // Quotient is known to fit 16 bits (mean of 16-bit values), so the remainder
    // starts from the sum's upper bits (< cnt) and only the low 16 bits are shifted in.
    always_comb begin
        trial_x   = {rem_x[CW-2:0], quo_x[15]};
        trial_y   = {rem_y[CW-2:0], quo_y[15]};
        rem_x_nxt = trial_x;
        rem_y_nxt = trial_y;
        quo_x_nxt = {quo_x[14:0], 1'b0};
        quo_y_nxt = {quo_y[14:0], 1'b0};
        if (trial_x >= divisor) begin
            rem_x_nxt = trial_x - divisor;
            quo_x_nxt[0] = 1'b1;
        end
        if (trial_y >= divisor) begin
            rem_y_nxt = trial_y - divisor;
            quo_y_nxt[0] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = (state != S_IDLE);
        data_valid = 1'b0;
        data_x     = '0;
        data_y     = '0;
        case (state)
            S_IDLE:   if (start) state_next = S_ASSIGN;
            S_ASSIGN: begin
                data_valid = 1'b1;
                data_x     = pt_x[issue_idx[AW-1:0]];
                data_y     = pt_y[issue_idx[AW-1:0]];
                if (issue_idx == LAST_IDX) state_next = S_DRAIN;
            end
            S_DRAIN:  if (all_back) state_next = S_UPDATE;
            S_UPDATE: if (div_last && div_k == 2'd3) state_next = S_CHECK;
            S_CHECK:  state_next = (!changed || iter_q == ITER_LIM) ? S_IDLE : S_ASSIGN;
            default:  state_next = S_IDLE;
        endcase
    end

    // Point memory is deliberately not reset.
    always_ff @(posedge clk) begin
        if (!rst && state == S_IDLE && ld_valid) begin
            pt_x[ld_addr] <= ld_x;
            pt_y[ld_addr] <= ld_y;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < 4; k++) begin
                cent_x[k] <= '0;
                cent_y[k] <= '0;
                sum_x[k]  <= '0;
                sum_y[k]  <= '0;
                cnt[k]    <= '0;
            end
            for (int p = 0; p < N_POINTS; p++) label[p] <= '0;
            changed     <= 1'b0;
            issue_idx   <= '0;
            result_idx  <= '0;
            div_k       <= '0;
            div_step    <= '0;
            rem_x       <= '0;
            rem_y       <= '0;
            quo_x       <= '0;
            quo_y       <= '0;
            divisor     <= '0;
            iter_q      <= '0;
            done_q      <= 1'b0;
            converged_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                S_IDLE: if (cinit_valid) begin
                    cent_x[cinit_idx] <= cinit_x;
                    cent_y[cinit_idx] <= cinit_y;
                end
                S_ASSIGN: issue_idx <= issue_idx + (AW+1)'(1);
                S_UPDATE: begin
                    if (div_step == 5'd0) begin
                        rem_x    <= CW'(sum_x[div_k][SW-1:16]);
                        rem_y    <= CW'(sum_y[div_k][SW-1:16]);
                        quo_x    <= sum_x[div_k][15:0];
                        quo_y    <= sum_y[div_k][15:0];
                        divisor  <= cnt[div_k];
                        div_step <= 5'd1;
                    end else begin
                        rem_x <= rem_x_nxt;
                        rem_y <= rem_y_nxt;
                        quo_x <= quo_x_nxt;
                        quo_y <= quo_y_nxt;
                        if (div_last) begin
                            // Empty cluster keeps its centroid but still spends its slot.
                            if (divisor != '0) begin
                                cent_x[div_k] <= quo_x_nxt;
                                cent_y[div_k] <= quo_y_nxt;
                            end
                            div_step <= 5'd0;
                            div_k    <= div_k + 2'd1;
                        end else begin
                            div_step <= div_step + 5'd1;
                        end
                    end
                end
                S_CHECK: if (state_next == S_IDLE) begin
                    done_q      <= 1'b1;
                    converged_q <= !changed;
                end
                default: ;
            endcase

            if (collect) begin
                sum_x[cluster_result] <= sum_x[cluster_result] + SW'(pt_x[r_addr]);
                sum_y[cluster_result] <= sum_y[cluster_result] + SW'(pt_y[r_addr]);
                cnt[cluster_result]   <= cnt[cluster_result] + CW'(1);
                label[r_addr]         <= cluster_result;
                // Stored labels are stale from a previous run on the first pass.
                if (iter_q == 4'd0 || label[r_addr] != cluster_result) changed <= 1'b1;
                result_idx <= result_idx + (AW+1)'(1);
            end

            if (state == S_DRAIN && state_next == S_UPDATE) iter_q <= iter_q + 4'd1;

            if ((state == S_IDLE && start) || (state == S_CHECK && state_next == S_ASSIGN)) begin
                for (int k = 0; k < 4; k++) begin
                    sum_x[k] <= '0;
                    sum_y[k] <= '0;
                    cnt[k]   <= '0;
                end
                changed    <= 1'b0;
                issue_idx  <= '0;
                result_idx <= '0;
                div_k      <= '0;
                div_step   <= '0;
                if (state == S_IDLE) begin
                    iter_q      <= '0;
                    converged_q <= 1'b0;
                end
            end
        end
    end

    assign cent_x_bus = {cent_x[3], cent_x[2], cent_x[1], cent_x[0]};
    assign cent_y_bus = {cent_y[3], cent_y[2], cent_y[1], cent_y[0]};
    assign done       = done_q;
    assign converged  = converged_q;
    assign iter_count = iter_q;
endmodule

// File: tb/tb_kmeans_iter_ctrl.sv
// tb/tb_kmeans_iter_ctrl.sv - self-checking bench for kmeans_iter_ctrl
module tb_kmeans_iter_ctrl;
    localparam int N = 4;
    localparam int ITER_PERIOD = 74;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1, start = 1'b1, ld_valid = 1'b0, cinit_valid = 1'b0;
    logic [1:0]  ld_addr = '0, cinit_idx = '0;
    logic [15:0] ld_x = '0, ld_y = '0, cinit_x = '0, cinit_y = '0;

    logic [15:0] d0_x, d0_y, d1_x, d1_y;
    logic        d0_v, d1_v, busy0, busy1, done0, done1, conv0, conv1;
    logic [63:0] c0x, c0y, c1x, c1y;
    logic [3:0]  it0, it1;
    logic [1:0]  r0 = '0, r1 = '0;
    logic        ov0 = 1'b0, ov1 = 1'b0;

    kmeans_iter_ctrl #(.N_POINTS(N), .ITER_MAX(8)) dut (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_x(ld_x), .ld_y(ld_y),
        .cinit_valid(cinit_valid), .cinit_idx(cinit_idx), .cinit_x(cinit_x), .cinit_y(cinit_y),
        .start(start), .data_x(d0_x), .data_y(d0_y), .data_valid(d0_v),
        .cent_x_bus(c0x), .cent_y_bus(c0y), .cluster_result(r0), .output_valid(ov0),
        .busy(busy0), .done(done0), .converged(conv0), .iter_count(it0));

    kmeans_iter_ctrl #(.N_POINTS(N), .ITER_MAX(1)) dut1 (
        .clk(clk), .rst(rst), .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_x(ld_x), .ld_y(ld_y),
        .cinit_valid(cinit_valid), .cinit_idx(cinit_idx), .cinit_x(cinit_x), .cinit_y(cinit_y),
        .start(start), .data_x(d1_x), .data_y(d1_y), .data_valid(d1_v),
        .cent_x_bus(c1x), .cent_y_bus(c1y), .cluster_result(r1), .output_valid(ov1),
        .busy(busy1), .done(done1), .converged(conv1), .iter_count(it1));

    function automatic logic [1:0] nearest(input logic [15:0] x, input logic [15:0] y,
                                           input logic [63:0] bx, input logic [63:0] by);
        longint best, d, dx, dy;
        logic [1:0] bi;
        best = 0;
        bi = 2'd0;
        for (int k = 0; k < 4; k++) begin
            dx = longint'(x) - longint'(bx[16*k +: 16]);
            dy = longint'(y) - longint'(by[16*k +: 16]);
            d = dx * dx + dy * dy;
            if (k == 0 || d < best) begin
                best = d;
                bi = 2'(k);
            end
        end
        return bi;
    endfunction

    // Assignment units: one-cycle latency, labels in issue order.
    always @(posedge clk) begin
        ov0 <= d0_v && !rst;
        r0  <= nearest(d0_x, d0_y, c0x, c0y);
        ov1 <= d1_v && !rst;
        r1  <= nearest(d1_x, d1_y, c1x, c1y);
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] m_px [N], m_py [N], m_cx0 [4], m_cy0 [4];
    logic [15:0] hx [0:8][0:3], hy [0:8][0:3];
    logic [15:0] m1x [4], m1y [4];
    int   m_iters = 1, m1_iters = 1;
    bit   m_conv, m1_conv;
    bit   run_on = 0, chk_reset = 0, lit_on = 0;
    int   start_cyc = 0, done_cyc = 0, done1_cyc = 0;
    logic [63:0] lit_cx, lit_cy;
    int   lit_it;
    bit   lit_cv;
    int   tests = 0, fails = 0;
    int   dv0 = 0, dv1 = 0;

    function automatic logic [63:0] hist_x(input int it);
        return {hx[it][3], hx[it][2], hx[it][1], hx[it][0]};
    endfunction
    function automatic logic [63:0] hist_y(input int it);
        return {hy[it][3], hy[it][2], hy[it][1], hy[it][0]};
    endfunction

    // Plain K-means: assign, accumulate, mean (floor), stop on no change or limit.
    task automatic model_run(input int itmax, output int iters, output bit conv);
        logic [1:0] lab [N];
        logic [1:0] prev [N];
        longint sx [4], sy [4];
        int cn [4];
        bit ch;
        for (int k = 0; k < 4; k++) begin
            hx[0][k] = m_cx0[k];
            hy[0][k] = m_cy0[k];
        end
        for (int p = 0; p < N; p++) prev[p] = 2'd0;
        iters = 0;
        conv = 0;
        for (int it = 0; it < itmax; it++) begin
            ch = (it == 0);
            for (int k = 0; k < 4; k++) begin
                sx[k] = 0; sy[k] = 0; cn[k] = 0;
            end
            for (int p = 0; p < N; p++) begin
                lab[p] = nearest(m_px[p], m_py[p], hist_x(it), hist_y(it));
                if (it > 0 && lab[p] != prev[p]) ch = 1;
                prev[p] = lab[p];
                sx[lab[p]] += longint'(m_px[p]);
                sy[lab[p]] += longint'(m_py[p]);
                cn[lab[p]] += 1;
            end
            for (int k = 0; k < 4; k++) begin
                hx[it+1][k] = (cn[k] != 0) ? 16'(sx[k] / cn[k]) : hx[it][k];
                hy[it+1][k] = (cn[k] != 0) ? 16'(sy[k] / cn[k]) : hy[it][k];
            end
            iters = it + 1;
            if (!ch) begin
                conv = 1;
                break;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Single compare process.
    always @(negedge clk) begin
        int it;
        if (chk_reset) begin
            chk("rst_busy", busy0, 0);
            chk("rst_done", done0, 0);
            chk("rst_data_valid", d0_v, 0);
            chk("rst_data_x", d0_x, 0);
            chk("rst_data_y", d0_y, 0);
            chk("rst_converged", conv0, 0);
            chk("rst_iter_count", it0, 0);
            chk("rst_cent_x", c0x, 0);
            chk("rst_cent_y", c0y, 0);
            chk("rst1_busy", busy1, 0);
            chk("rst1_done", done1, 0);
            chk("rst1_iter_count", it1, 0);
        end else begin
            if (run_on && cyc == start_cyc) begin
                dv0 = 0;
                dv1 = 0;
            end
            chk("busy", busy0, run_on && cyc > start_cyc && cyc < done_cyc);
            chk("done", done0, run_on && cyc == done_cyc);
            chk("busy1", busy1, run_on && cyc > start_cyc && cyc < done1_cyc);
            chk("done1", done1, run_on && cyc == done1_cyc);
            if (run_on && d0_v) begin
                it = (dv0 / N > 8) ? 8 : dv0 / N;
                chk("data_x", d0_x, m_px[dv0 % N]);
                chk("data_y", d0_y, m_py[dv0 % N]);
                chk("cent_x_in_assign", c0x, hist_x(it));
                chk("cent_y_in_assign", c0y, hist_y(it));
                dv0++;
            end
            if (run_on && d1_v) begin
                chk("data1_x", d1_x, m_px[dv1 % N]);
                chk("cent1_x_in_assign", c1x, hist_x(0));
                dv1++;
            end
            if (run_on && cyc == done_cyc) begin
                chk("converged", conv0, m_conv);
                chk("iter_count", it0, m_iters);
                chk("final_cent_x", c0x, hist_x(m_iters));
                chk("final_cent_y", c0y, hist_y(m_iters));
                chk("data_valid_total", dv0, N * m_iters);
                if (lit_on) begin
                    chk("lit_cent_x", c0x, lit_cx);
                    chk("lit_cent_y", c0y, lit_cy);
                    chk("lit_iter_count", it0, lit_it);
                    chk("lit_converged", conv0, lit_cv);
                end
            end
            if (run_on && cyc == done1_cyc) begin
                chk("converged1", conv1, m1_conv);
                chk("iter_count1", it1, m1_iters);
                chk("final1_cent_x", c1x, {m1x[3], m1x[2], m1x[1], m1x[0]});
                chk("final1_cent_y", c1y, {m1y[3], m1y[2], m1y[1], m1y[0]});
                if (lit_on) begin
                    chk("lit1_cent_x", c1x, lit_cx);
                    chk("lit1_cent_y", c1y, lit_cy);
                    chk("lit1_iter_count", it1, 1);
                    chk("lit1_converged", conv1, 0);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_points();
        for (int p = 0; p < N; p++) begin
            ld_valid = 1'b1; ld_addr = 2'(p); ld_x = m_px[p]; ld_y = m_py[p];
            tick();
        end
        ld_valid = 1'b0;
    endtask

    task automatic load_cents();
        for (int k = 0; k < 4; k++) begin
            cinit_valid = 1'b1; cinit_idx = 2'(k); cinit_x = m_cx0[k]; cinit_y = m_cy0[k];
            tick();
        end
        cinit_valid = 1'b0;
    endtask

    task automatic kick_start(input bit same_load);
        model_run(1, m1_iters, m1_conv);
        for (int k = 0; k < 4; k++) begin
            m1x[k] = hx[1][k];
            m1y[k] = hy[1][k];
        end
        model_run(8, m_iters, m_conv);
        start = 1'b1;
        if (same_load) begin
            ld_valid = 1'b1; ld_addr = 2'd3; ld_x = m_px[3]; ld_y = m_py[3];
        end
        start_cyc = cyc;
        done_cyc  = cyc + 1 + ITER_PERIOD * m_iters;
        done1_cyc = cyc + 1 + ITER_PERIOD * m1_iters;
        run_on = 1;
        tick();
        start = 1'b0;
        ld_valid = 1'b0;
    endtask

    task automatic do_run(input bit poke, input bit same_load);
        kick_start(same_load);
        if (poke) begin
            tick();
            start = 1'b1;
            ld_valid = 1'b1; ld_addr = 2'd0; ld_x = ~m_px[0]; ld_y = ~m_py[0];
            tick();
            start = 1'b0;
            ld_valid = 1'b0;
        end
        while (cyc <= done_cyc + 1) tick();
        run_on = 0;
        tick();
    endtask

    task automatic set_basic();
        m_cx0[0] = 16'h0100; m_cy0[0] = 16'h0100;
        m_cx0[1] = 16'h0800; m_cy0[1] = 16'h0800;
        m_cx0[2] = 16'h0100; m_cy0[2] = 16'h0800;
        m_cx0[3] = 16'h0800; m_cy0[3] = 16'h0100;
        m_px[0] = 16'h0200; m_py[0] = 16'h0200;
        m_px[1] = 16'h0300; m_py[1] = 16'h0300;
        m_px[2] = 16'h0680; m_py[2] = 16'h0600;
        m_px[3] = 16'h0780; m_py[3] = 16'h0700;
        lit_on = 1;
        lit_cx = 64'h0800_0100_0700_0280;
        lit_cy = 64'h0100_0800_0680_0280;
        lit_it = 2;
        lit_cv = 1;
    endtask

    initial begin
        // Reset held two cycles with start asserted throughout.
        tick();
        chk_reset = 1;
        tick();
        rst = 1'b0;
        start = 1'b0;
        tick();
        tick();
        chk_reset = 0;

        set_basic();
        load_points();
        load_cents();
        do_run(0, 0);

        // start and ld_valid pulsed mid-ASSIGN must be ignored.
        load_cents();
        do_run(1, 0);

        // Truncating division: 0x0402 / 4.
        m_px[0] = 16'h0100; m_px[1] = 16'h0101; m_px[2] = 16'h0101; m_px[3] = 16'h0100;
        for (int p = 0; p < N; p++) m_py[p] = 16'h0000;
        m_cx0[0] = 16'h0100; m_cy0[0] = 16'h0000;
        m_cx0[1] = 16'h8000; m_cy0[1] = 16'h8000;
        m_cx0[2] = 16'hF000; m_cy0[2] = 16'h1000;
        m_cx0[3] = 16'h1000; m_cy0[3] = 16'hF000;
        lit_cx = 64'h1000_F000_8000_0100;
        lit_cy = 64'hF000_1000_8000_0000;
        lit_it = 2;
        lit_cv = 1;
        load_points();
        load_cents();
        do_run(0, 0);

        // Reset during UPDATE, then a fresh basic run.
        set_basic();
        load_points();
        load_cents();
        kick_start(0);
        while (cyc < start_cyc + 12) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        run_on = 0;
        chk_reset = 1;
        tick();
        chk_reset = 0;
        repeat (100) tick();
        load_cents();
        do_run(0, 0);

        // Randomized runs; some also load a point in the start cycle.
        lit_on = 0;
        for (int t = 0; t < 8; t++) begin
            for (int p = 0; p < N; p++) begin
                m_px[p] = 16'($urandom_range(0, 65535));
                m_py[p] = 16'($urandom_range(0, 65535));
            end
            for (int k = 0; k < 4; k++) begin
                m_cx0[k] = 16'($urandom_range(0, 65535));
                m_cy0[k] = 16'($urandom_range(0, 65535));
            end
            load_points();
            load_cents();
            if (t % 2 == 1) begin
                m_px[3] = 16'($urandom_range(0, 65535));
                m_py[3] = 16'($urandom_range(0, 65535));
            end
            do_run(0, t % 2 == 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
